// File: rtl/bpu_gshare_pkg.sv
// Shared types and helpers for the gshare branch prediction unit.
// Holds the BTB entry layout, PHT counter type, FSM states and the counter update rule.
package bpu_pkg;

  localparam int PC_IDX_LSB = 2;
  localparam int BTB_TAG_W  = 20;

  typedef logic [1:0] pht_cnt_t;

  localparam pht_cnt_t PHT_WEAK_NT = 2'b01;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          target;
  } btb_entry_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bpu_state_e;

  function automatic pht_cnt_t sat_update(input pht_cnt_t cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'd1;
    return (cnt == 2'b00) ? cnt : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bpu_pht_bank.sv
// Pattern history table of 2-bit counters: combinational read lanes, prioritised
// update ports (highest port wins on a shared index) and an init-sweep write port.
module bpu_pht_bank
  import bpu_pkg::*;
#(
  parameter int ENTRIES = 1024,
  parameter int RD_W    = 3,
  parameter int WR_W    = 2,
  parameter int IDX_W   = 10
) (
  input  logic                       clk,
  input  logic [RD_W-1:0][IDX_W-1:0] i_rd_idx,
  output pht_cnt_t [RD_W-1:0]        o_rd_cnt,
  input  logic                       i_init_we,
  input  logic [IDX_W-1:0]           i_init_idx,
  input  logic [WR_W-1:0]            i_wr_en,
  input  logic [WR_W-1:0][IDX_W-1:0] i_wr_idx,
  input  logic [WR_W-1:0]            i_wr_taken
);

  pht_cnt_t r_pht [ENTRIES];

  always_comb begin
    for (int i = 0; i < RD_W; i++) o_rd_cnt[i] = r_pht[i_rd_idx[i]];
  end

  // Every port reads the pre-edge value; later loop iterations overwrite earlier ones.
  always_ff @(posedge clk) begin
    if (i_init_we) begin
      r_pht[i_init_idx] <= PHT_WEAK_NT;
    end else begin
      for (int k = 0; k < WR_W; k++) begin
        if (i_wr_en[k]) r_pht[i_wr_idx[k]] <= sat_update(r_pht[i_wr_idx[k]], i_wr_taken[k]);
      end
    end
  end

endmodule

// File: rtl/bpu_gshare.sv
// Multi-lane gshare branch predictor: direct-mapped BTB, PHT bank, speculative GHR
// with mispredict recovery, and a post-reset sweep that initialises the tables.
module bpu_gshare
  import bpu_pkg::*;
#(
  parameter int FETCH_W     = 3,
  parameter int UPD_W       = 2,
  parameter int BTB_ENTRIES = 64,
  parameter int PHT_ENTRIES = 1024,
  parameter int GHR_W       = 10,
  parameter int TAG_W       = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          bpu_ready,
  input  logic                          fetch_fire,
  input  logic [FETCH_W-1:0][31:0]      pc,
  output logic [FETCH_W-1:0]            predict_valid,
  output logic [FETCH_W-1:0]            predict,
  output logic [FETCH_W-1:0][31:0]      pc_predict,
  output logic [FETCH_W-1:0][GHR_W-1:0] pht_idx,
  output logic [GHR_W-1:0]              ghr_snap,
  input  logic [UPD_W-1:0]              upd_valid,
  input  logic [UPD_W-1:0][31:0]        upd_pc,
  input  logic [UPD_W-1:0][GHR_W-1:0]   upd_pht_idx,
  input  logic [UPD_W-1:0]              upd_taken,
  input  logic [UPD_W-1:0][31:0]        upd_target,
  input  logic [UPD_W-1:0]              upd_mispredict,
  input  logic [UPD_W-1:0][GHR_W-1:0]   upd_ghr,
  output bpu_state_e                    dbg_state
);

  localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_LSB   = PC_IDX_LSB + BTB_IDX_W;

  bpu_state_e         r_state;
  logic [GHR_W-1:0]   r_cnt;
  logic               r_ready;
  logic [GHR_W-1:0]   r_ghr;
  btb_entry_t         r_btb [BTB_ENTRIES];

  logic [FETCH_W-1:0][BTB_IDX_W-1:0] w_bidx;
  logic [FETCH_W-1:0]                w_hit;
  logic [FETCH_W-1:0]                w_lane_taken;
  pht_cnt_t [FETCH_W-1:0]            w_cnt;
  logic                              w_any_hit;
  logic                              w_seen;
  logic                              w_recover;
  logic [GHR_W-1:0]                  w_rec_ghr;
  logic                              w_rec_taken;
  logic                              w_upd_en;
  logic                              w_unused;

  assign bpu_ready = r_ready;
  assign ghr_snap  = r_ghr;
  assign dbg_state = r_state;
  assign w_upd_en  = (r_state == ST_RUN) && !rst;
  assign w_unused  = ^{upd_pc, w_cnt};

  always_comb begin
    for (int i = 0; i < FETCH_W; i++) begin
      w_bidx[i]  = pc[i][PC_IDX_LSB +: BTB_IDX_W];
      pht_idx[i] = pc[i][PC_IDX_LSB +: GHR_W] ^ r_ghr;
      w_hit[i]   = r_btb[w_bidx[i]].valid && (r_btb[w_bidx[i]].tag == pc[i][TAG_LSB +: TAG_W]);
    end
  end

  bpu_pht_bank #(
    .ENTRIES (PHT_ENTRIES),
    .RD_W    (FETCH_W),
    .WR_W    (UPD_W),
    .IDX_W   (GHR_W)
  ) u_pht (
    .clk        (clk),
    .i_rd_idx   (pht_idx),
    .o_rd_cnt   (w_cnt),
    .i_init_we  (r_state == ST_INIT),
    .i_init_idx (r_cnt),
    .i_wr_en    (upd_valid & {UPD_W{w_upd_en}}),
    .i_wr_idx   (upd_pht_idx),
    .i_wr_taken (upd_taken)
  );

  // The first taken lane closes the group; lanes after it are not valid.
  always_comb begin
    w_seen    = 1'b0;
    w_any_hit = 1'b0;
    for (int i = 0; i < FETCH_W; i++) begin
      w_lane_taken[i]  = w_hit[i] && w_cnt[i][1] && r_ready;
      predict_valid[i] = r_ready && !w_seen;
      predict[i]       = w_lane_taken[i] && predict_valid[i];
      pc_predict[i]    = predict[i] ? r_btb[w_bidx[i]].target : pc[i] + 32'd4;
      if (predict_valid[i] && w_hit[i]) w_any_hit = 1'b1;
      if (w_lane_taken[i]) w_seen = 1'b1;
    end
  end

  always_comb begin
    w_recover   = 1'b0;
    w_rec_ghr   = '0;
    w_rec_taken = 1'b0;
    for (int k = UPD_W - 1; k >= 0; k--) begin
      if (upd_valid[k] && upd_mispredict[k]) begin
        w_recover   = 1'b1;
        w_rec_ghr   = upd_ghr[k];
        w_rec_taken = upd_taken[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == GHR_W'(PHT_ENTRIES - 1)) r_state <= ST_RUN;
        end
        ST_RUN:  r_ready <= 1'b1;
        default: r_state <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (w_upd_en && w_recover) begin
      r_ghr <= {w_rec_ghr[GHR_W-2:0], w_rec_taken};
    end else if (r_ready && fetch_fire && w_any_hit) begin
      r_ghr <= {r_ghr[GHR_W-2:0], |predict};
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_btb[r_cnt[BTB_IDX_W-1:0]].valid <= 1'b0;
    end else if (w_upd_en) begin
      for (int k = 0; k < UPD_W; k++) begin
        if (upd_valid[k] && upd_taken[k]) begin
          r_btb[upd_pc[k][PC_IDX_LSB +: BTB_IDX_W]] <= '{1'b1, upd_pc[k][TAG_LSB +: TAG_W], upd_target[k]};
        end
      end
    end
  end

endmodule

// File: tb/tb_bpu_gshare.sv
// Bench for bpu_gshare: directed steps then random traffic, all checked against
// an array-based reference predictor.
module tb_bpu_gshare;
  import bpu_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             bpu_ready;
  logic             fetch_fire;
  logic [2:0][31:0] pc;
  logic [2:0]       predict_valid;
  logic [2:0]       predict;
  logic [2:0][31:0] pc_predict;
  logic [2:0][9:0]  pht_idx;
  logic [9:0]       ghr_snap;
  logic [1:0]       upd_valid;
  logic [1:0][31:0] upd_pc;
  logic [1:0][9:0]  upd_pht_idx;
  logic [1:0]       upd_taken;
  logic [1:0][31:0] upd_target;
  logic [1:0]       upd_mispredict;
  logic [1:0][9:0]  upd_ghr;
  bpu_state_e       dbg_state;

  int checks = 0;
  int errors = 0;

  int          m_pht [1024];
  bit          m_bv  [64];
  logic [19:0] m_tag [64];
  logic [31:0] m_tgt [64];
  logic [9:0]  m_ghr;
  bit          m_ready;

  logic [2:0]  exp_pv, exp_pred;
  logic [31:0] exp_pcp [3];
  logic [9:0]  exp_idx [3];
  bit          exp_any_hit;
  logic [2:0]  obs_pv, obs_pred;
  logic [31:0] obs_pcp [3];
  logic [9:0]  obs_ghr;

  logic [31:0] pool [4] = '{32'h1C00_0000, 32'h2000_0040, 32'h1C00_0100, 32'h3000_0228};

  bpu_gshare dut (
    .clk            (clk),
    .rst            (rst),
    .bpu_ready      (bpu_ready),
    .fetch_fire     (fetch_fire),
    .pc             (pc),
    .predict_valid  (predict_valid),
    .predict        (predict),
    .pc_predict     (pc_predict),
    .pht_idx        (pht_idx),
    .ghr_snap       (ghr_snap),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_pht_idx    (upd_pht_idx),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict),
    .upd_ghr        (upd_ghr),
    .dbg_state      (dbg_state)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_pc(input logic [31:0] base);
    for (int i = 0; i < 3; i++) pc[i] = base + 32'(4 * i);
  endtask

  task automatic clear_upd();
    upd_valid = '0; upd_pc = '0; upd_pht_idx = '0; upd_taken = '0;
    upd_target = '0; upd_mispredict = '0; upd_ghr = '0;
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 1024; i++) m_pht[i] = 1;
    for (int i = 0; i < 64; i++) m_bv[i] = 1'b0;
    m_ghr   = '0;
    m_ready = 1'b0;
  endtask

  task automatic mdl_lookup(input logic [31:0] base);
    bit stop, hit, tk;
    logic [31:0] p;
    int bi;
    stop = 1'b0; exp_pv = '0; exp_pred = '0; exp_any_hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      p          = base + 32'(4 * i);
      bi         = int'((p >> 2) % 64);
      exp_idx[i] = 10'((p >> 2) & 32'h3FF) ^ m_ghr;
      hit        = m_bv[bi] && (m_tag[bi] == 20'(p >> 8));
      tk         = hit && (m_pht[exp_idx[i]] >= 2) && m_ready;
      exp_pv[i]   = m_ready && !stop;
      exp_pred[i] = tk && exp_pv[i];
      exp_pcp[i]  = exp_pred[i] ? m_tgt[bi] : p + 32'd4;
      if (exp_pv[i] && hit) exp_any_hit = 1'b1;
      if (tk) stop = 1'b1;
    end
  endtask

  task automatic mdl_step();
    int nv [2];
    bit rec;
    int bi;
    for (int k = 0; k < 2; k++) begin
      nv[k] = m_pht[upd_pht_idx[k]];
      if (upd_taken[k]) nv[k] = (nv[k] < 3) ? nv[k] + 1 : 3;
      else              nv[k] = (nv[k] > 0) ? nv[k] - 1 : 0;
    end
    for (int k = 0; k < 2; k++) if (upd_valid[k]) m_pht[upd_pht_idx[k]] = nv[k];
    for (int k = 0; k < 2; k++) begin
      if (upd_valid[k] && upd_taken[k]) begin
        bi        = int'((upd_pc[k] >> 2) % 64);
        m_bv[bi]  = 1'b1;
        m_tag[bi] = 20'(upd_pc[k] >> 8);
        m_tgt[bi] = upd_target[k];
      end
    end
    rec = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (!rec && upd_valid[k] && upd_mispredict[k]) begin
        rec   = 1'b1;
        m_ghr = 10'({upd_ghr[k], upd_taken[k]});
      end
    end
    if (!rec && fetch_fire && m_ready && exp_any_hit) m_ghr = 10'({m_ghr, exp_pred != 3'b000});
  endtask

  // One clock: compare outputs against the model mid-cycle, then advance the model.
  task automatic cycle();
    @(negedge clk);
    mdl_lookup(pc[0]);
    obs_pv = predict_valid; obs_pred = predict; obs_ghr = ghr_snap;
    for (int i = 0; i < 3; i++) obs_pcp[i] = pc_predict[i];
    chk("ready", 32'(bpu_ready), 32'(m_ready));
    chk("predict_valid", 32'(predict_valid), 32'(exp_pv));
    chk("predict", 32'(predict), 32'(exp_pred));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("pc_predict%0d", i), pc_predict[i], exp_pcp[i]);
      chk($sformatf("pht_idx%0d", i), 32'(pht_idx[i]), 32'(exp_idx[i]));
    end
    chk("ghr_snap", 32'(ghr_snap), 32'(m_ghr));
    mdl_step();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (bpu_ready !== 1'b1 && cyc < 3000) begin
      chk("sweep_predict_valid", 32'(predict_valid), 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    logic [31:0] b;
    rst = 1'b1; fetch_fire = 1'b0;
    set_pc(32'h1C00_0000);
    clear_upd();
    mdl_reset();
    @(posedge clk); #1;

    chk("rst_ready", 32'(bpu_ready), 32'd0);
    chk("rst_predict_valid", 32'(predict_valid), 32'd0);
    chk("rst_predict", 32'(predict), 32'd0);
    chk("rst_pc_predict0", pc_predict[0], 32'h1C00_0004);
    chk("rst_ghr_snap", 32'(ghr_snap), 32'd0);
    rst = 1'b0;
    wait_ready(cyc);
    chk("sweep_cycles", 32'(cyc), 32'd1025);
    m_ready = 1'b1;

    // Cold lookup
    cycle();
    chk("cold_predict", 32'(obs_pred), 32'h0);
    chk("cold_pv", 32'(obs_pv), 32'h7);
    chk("cold_pcp2", obs_pcp[2], 32'h1C00_000C);

    // Train lane 1 twice with GHR held at zero
    upd_valid = 2'b01; upd_pc[0] = 32'h1C00_0004; upd_pht_idx[0] = 10'h001;
    upd_taken = 2'b01; upd_target[0] = 32'h1C00_0100;
    cycle();
    cycle();
    clear_upd();
    cycle();
    chk("train_predict", 32'(obs_pred), 32'h2);
    chk("train_pv", 32'(obs_pv), 32'h3);
    chk("train_pcp1", obs_pcp[1], 32'h1C00_0100);

    // Speculative shift, then recovery overriding a simultaneous fetch
    fetch_fire = 1'b1;
    cycle();
    fetch_fire = 1'b0;
    cycle();
    chk("ghr_shift", 32'(obs_ghr), 32'h001);
    fetch_fire = 1'b1;
    upd_valid = 2'b01; upd_pc[0] = 32'h1C00_0004; upd_pht_idx[0] = 10'h001;
    upd_taken = 2'b00; upd_mispredict = 2'b01; upd_ghr[0] = 10'h155;
    cycle();
    fetch_fire = 1'b0;
    clear_upd();
    cycle();
    chk("ghr_recover", 32'(obs_ghr), 32'h2AA);

    // Both ports on one PHT index: port 1 (not taken) must win over port 0
    b = 32'h2000_0040;
    upd_valid = 2'b11; upd_pc[0] = b; upd_pc[1] = b;
    upd_pht_idx[0] = 10'((b >> 2) & 32'h3FF) ^ m_ghr;
    upd_pht_idx[1] = upd_pht_idx[0];
    upd_taken = 2'b01; upd_target[0] = 32'h2000_0800;
    cycle();
    clear_upd();
    set_pc(b);
    cycle();
    chk("collide_predict", 32'(obs_pred), 32'h0);
    chk("collide_pcp0", obs_pcp[0], 32'h2000_0044);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      set_pc(pool[$urandom_range(0, 3)] + 32'(4 * $urandom_range(0, 3)));
      fetch_fire = 1'($urandom_range(0, 1));
      for (int k = 0; k < 2; k++) begin
        upd_valid[k]      = ($urandom_range(0, 1) == 1);
        upd_pc[k]         = pool[$urandom_range(0, 3)] + 32'(4 * $urandom_range(0, 5));
        upd_pht_idx[k]    = ($urandom_range(0, 1) == 1) ? (10'((upd_pc[k] >> 2) & 32'h3FF) ^ m_ghr)
                                                        : 10'($urandom_range(0, 1023));
        upd_taken[k]      = ($urandom_range(0, 3) != 0);
        upd_target[k]     = $urandom & 32'hFFFF_FFFC;
        upd_mispredict[k] = ($urandom_range(0, 7) == 0);
        upd_ghr[k]        = 10'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 3) == 0) begin
        upd_pht_idx[1] = upd_pht_idx[0];
        upd_pc[1]      = upd_pc[0];
      end
      cycle();
    end
    clear_upd();
    fetch_fire = 1'b0;

    // Reset in RUN, then again mid-sweep; the sweep must restart from zero
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_reset();
    repeat (499) @(posedge clk);
    #1;
    chk("midsweep_ready", 32'(bpu_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ready(cyc);
    chk("resweep_cycles", 32'(cyc), 32'd1025);
    m_ready = 1'b1;
    set_pc(32'h1C00_0000);
    cycle();
    chk("resweep_predict", 32'(obs_pred), 32'h0);
    chk("resweep_ghr", 32'(obs_ghr), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
